mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one memory/peripheral bus between the instruction-fetch port and the load/store port of the core.
- Arbitrates between the two requesters and decodes the winning word address into the RAM region or the IO region.
- Sequences exactly one outstanding transaction at a time.
- Returns read data, or a completion for writes, to the originating requester; unmapped addresses are flagged with an error response.

Parameters:
- RAM_LATENCY, 1, cycles from ram_req to valid ram_rdata (>=1).
- CNT_W, 4, width of the RAM latency counter (must hold RAM_LATENCY).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- i_req  in  1  fetch request, held until i_gnt
- i_addr  in  30  fetch word address
- i_gnt  out  1  fetch request accepted (1-cycle pulse)
- i_rvalid  out  1  fetch response (1-cycle pulse)
- i_rdata  out  32  fetch read data, valid with i_rvalid
- i_err  out  1  unmapped-address error, valid with i_rvalid
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  data write enable
- d_be  in  4  data byte enables
- d_addr  in  30  data word address
- d_wdata  in  32  data write data
- d_gnt, d_rvalid, d_rdata[31:0], d_err  out  as fetch port
- ram_req  out  1  RAM strobe (1 cycle)
- ram_we  out  1  RAM write enable
- ram_be  out  4  RAM byte enables
- ram_addr  out  30  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data
- io_req  out  1  IO request, held until io_ready
- io_we, io_be[3:0], io_addr[29:0], io_wdata[31:0]  out  IO command, stable while io_req is high
- io_ready  in  1  IO completion
- io_rdata  in  32  IO read data, valid with io_ready

Behaviour:
- Region decode on the granted address:
  - RAM when addr[29:26]==4'h0.
  - IO when addr[29:14]==16'hF000.
  - Anything else is unmapped.
- Fetch requests are always reads: we=0, be=4'hF.
- FSM states: IDLE, RAM_ISSUE, RAM_WAIT, IO_WAIT, ERR_RESP.
- IDLE:
  - If any request is present in cycle T: arbitrate, assert the winner's gnt combinationally in T, and latch the winner id, we, be, addr and wdata.
  - Next state: RAM_ISSUE, IO_WAIT or ERR_RESP, according to the decode.
  - The loser keeps its req high and is served later.
- Default arbitration: fixed priority, data port over fetch port.
- RAM_ISSUE (T+1):
  - ram_req=1 with latched fields.
  - Load the counter with RAM_LATENCY, then go to RAM_WAIT.
- RAM_WAIT:
  - Decrement the counter each cycle.
  - At count==1 (cycle T+1+RAM_LATENCY): assert the owner's rvalid, with rdata=ram_rdata passed through combinationally and err=0.
  - Then go to IDLE.
- IO_WAIT:
  - io_req=1 with latched fields from T+1 until the cycle io_ready=1.
  - In that cycle, capture io_rdata into a register; the owner's rvalid pulses next cycle with that data and err=0.
  - Then go to IDLE.
  - There is no timeout.
- ERR_RESP (T+1):
  - Owner's rvalid=1, err=1, rdata=0.
  - No RAM/IO strobe is issued.
  - Then go to IDLE.
- Writes also complete with rvalid; rdata is don't-care (drive 0 for IO writes).
- Back-to-back: a new grant is possible in the IDLE cycle immediately after the rvalid cycle.
  - Minimum RAM transaction period = RAM_LATENCY+2 cycles.
- Outputs driven only to the owner; the non-owner's gnt, rvalid and err stay 0.
- Reset values: state=IDLE; all gnt, rvalid, err, ram_req, io_req = 0; all latched fields and rdata = 0; round-robin pointer = fetch-preferred.
- Reset mid-operation: the transaction is dropped silently, with no rvalid. io_req drops immediately; IO slaves must tolerate abort.
- Request changes before gnt are legal; the address is sampled only in the grant cycle.

Optional Feature:
- ARB_ROUND_ROBIN_EN.
- Defined: two-requester round robin.
  - A 1-bit pointer names the preferred port on contention.
  - After each grant the pointer flips to the other port.
  - With no contention the sole requester wins, and the pointer still flips to the other port.
  - Reset pointer prefers fetch.
- Undefined: fixed priority, data over fetch; the pointer logic is absent.

Test Plan:
- Fetch read, i_addr=30'h0000_0010, RAM_LATENCY=1, ram_rdata=32'hDEAD_BEEF:
  - i_gnt at T, ram_req at T+1, i_rvalid with 32'hDEAD_BEEF at T+2, i_err=0.
- i_req and d_req both high in T, RAM addresses, macro undefined:
  - d_gnt at T; i_gnt in the IDLE cycle after d_rvalid.
  - With ARB_ROUND_ROBIN_EN, the first contention grants fetch, and grants alternate on sustained contention.
- Data write to IO, d_addr=30'h3C00_0004, d_wdata=32'h0000_00A5, d_be=4'h1, io_ready after 3 cycles:
  - io_req high with stable fields for 3 cycles, d_rvalid the cycle after io_ready, d_err=0.
- Data read, d_addr=30'h2000_0000 (unmapped):
  - d_gnt at T, d_rvalid=1 with d_err=1 and d_rdata=0 at T+1, ram_req and io_req never asserted.
- IO read in progress, rst asserted while io_req=1:
  - io_req=0 immediately, no d_rvalid, state IDLE.
  - After release, a fresh request is granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port (fetch/data) arbiter onto a RAM region and an IO region
// ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise data has fixed priority over fetch.
`timescale 1ns/1ps
module mem_bus_arbiter #(
    parameter int RAM_LATENCY = 1,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [29:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [29:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        ram_req,
    output logic        ram_we,
    output logic [3:0]  ram_be,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        io_req,
    output logic        io_we,
    output logic [3:0]  io_be,
    output logic [29:0] io_addr,
    output logic [31:0] io_wdata,
    input  logic        io_ready,
    input  logic [31:0] io_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RAM_ISSUE,
        RAM_WAIT,
        IO_WAIT,
        IO_RESP,
        ERR_RESP
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;   // 1 = data port owns the bus
    logic               we_q, we_d;
    logic [3:0]         be_q, be_d;
    logic [29:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               win_d;              // 1 = data port wins this IDLE cycle
    logic [29:0]        sel_addr;
    logic               rvalid;
    logic               resp_err;
    logic [31:0]        resp_data;

`ifdef ARB_ROUND_ROBIN_EN
    logic               rr_ptr_q, rr_ptr_d; // 1 = data preferred on contention

    always_comb begin
        win_d    = d_req && (!i_req || rr_ptr_q);
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && (i_req || d_req)) begin
            rr_ptr_d = ~win_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        win_d = d_req;
    end
`endif

    assign sel_addr = win_d ? d_addr : i_addr;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        rvalid    = 1'b0;
        resp_err  = 1'b0;
        resp_data = 32'h0;
        ram_req   = 1'b0;
        io_req    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    d_gnt   = win_d;
                    i_gnt   = ~win_d;
                    owner_d = win_d;
                    addr_d  = sel_addr;
                    we_d    = win_d ? d_we : 1'b0;
                    be_d    = win_d ? d_be : 4'hF;
                    wdata_d = win_d ? d_wdata : 32'h0;
                    if (sel_addr[29:26] == 4'h0) begin
                        state_d = RAM_ISSUE;
                    end else if (sel_addr[29:14] == 16'hF000) begin
                        state_d = IO_WAIT;
                    end else begin
                        state_d = ERR_RESP;
                    end
                end
            end
            RAM_ISSUE: begin
                ram_req = 1'b1;
                cnt_d   = CNT_W'(RAM_LATENCY);
                state_d = RAM_WAIT;
            end
            RAM_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    rvalid    = 1'b1;
                    resp_data = ram_rdata;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            IO_WAIT: begin
                io_req = 1'b1;
                if (io_ready) begin
                    rdata_d = we_q ? 32'h0 : io_rdata;
                    state_d = IO_RESP;
                end
            end
            IO_RESP: begin
                rvalid    = 1'b1;
                resp_data = rdata_q;
                state_d   = IDLE;
            end
            ERR_RESP: begin
                rvalid   = 1'b1;
                resp_err = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            addr_q  <= 30'h0;
            wdata_q <= 32'h0;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Both slaves see the latched command; only the strobes qualify it.
    assign ram_we    = we_q;
    assign ram_be    = be_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign io_we     = we_q;
    assign io_be     = be_q;
    assign io_addr   = addr_q;
    assign io_wdata  = wdata_q;

    assign i_rvalid = rvalid & ~owner_q;
    assign i_err    = resp_err & ~owner_q;
    assign i_rdata  = (rvalid & ~owner_q) ? resp_data : 32'h0;
    assign d_rvalid = rvalid & owner_q;
    assign d_err    = resp_err & owner_q;
    assign d_rdata  = (rvalid & owner_q) ? resp_data : 32'h0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized self-checking bench for mem_bus_arbiter
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int RAM_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_gnt, i_rvalid, i_err;
    logic [29:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [3:0]  d_be;
    logic [29:0] d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        ram_req, ram_we;
    logic [3:0]  ram_be;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        io_req, io_we, io_ready;
    logic [3:0]  io_be;
    logic [29:0] io_addr;
    logic [31:0] io_wdata, io_rdata;

    int n_checks = 0;
    int n_errors = 0;
    bit rr_ptr = 1'b0;   // model pointer: 1 = data preferred

    mem_bus_arbiter #(.RAM_LATENCY(RAM_LAT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .ram_req(ram_req), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .io_req(io_req), .io_we(io_we), .io_be(io_be), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_ready(io_ready), .io_rdata(io_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_model(input logic [29:0] a);
        if (a == 30'h10) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign ram_rdata = ram_model(ram_addr);

    // 0 = RAM, 1 = IO, 2 = unmapped
    function automatic int region(input logic [29:0] a);
        if (a < 30'h0400_0000) return 0;
        if (a >= 30'h3C00_0000 && a < 30'h3C00_4000) return 1;
        return 2;
    endfunction

    function automatic logic [29:0] rand_addr();
        case ($urandom_range(0, 2))
            0:       return 30'($urandom) & 30'h03FF_FFFF;
            1:       return 30'h3C00_0000 | (30'($urandom) & 30'h0000_3FFF);
            default: return 30'h0400_0000 + 30'($urandom_range(0, 32'h37FF_FFFF));
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pick(input bit ir, input bit dr, output bit w);
`ifdef ARB_ROUND_ROBIN_EN
        w      = (ir && dr) ? rr_ptr : dr;
        rr_ptr = ~w;
`else
        w = dr;
`endif
    endtask

    task automatic check_resp(input bit is_d, input bit e_err, input logic [31:0] e_data,
                              input bit chk_data);
        check("owner_rvalid", 32'(is_d ? d_rvalid : i_rvalid), 32'd1);
        check("owner_err", 32'(is_d ? d_err : i_err), 32'(e_err));
        if (chk_data) check("owner_rdata", is_d ? d_rdata : i_rdata, e_data);
        check("other_rvalid", 32'(is_d ? i_rvalid : d_rvalid), 32'd0);
        check("other_err", 32'(is_d ? i_err : d_err), 32'd0);
        check("gnt_busy", 32'(i_gnt | d_gnt), 32'd0);
    endtask

    // Entered at posedge+1 of the grant cycle; returns at posedge+1 of the next IDLE cycle.
    task automatic serve(input bit is_d, input int k);
        logic [29:0] a;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd, io_val;
        a  = is_d ? d_addr : i_addr;
        we = is_d ? d_we : 1'b0;
        be = is_d ? d_be : 4'hF;
        wd = d_wdata;
        @(negedge clk);
        check(is_d ? "d_gnt" : "i_gnt", 32'(is_d ? d_gnt : i_gnt), 32'd1);
        check("loser_gnt", 32'(is_d ? i_gnt : d_gnt), 32'd0);
        @(posedge clk); #1;
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
        case (region(a))
            0: begin
                @(negedge clk);
                check("ram_req", 32'(ram_req), 32'd1);
                check("ram_addr", 32'(ram_addr), 32'(a));
                check("ram_we", 32'(ram_we), 32'(we));
                check("ram_be", 32'(ram_be), 32'(be));
                if (we) check("ram_wdata", ram_wdata, wd);
                check("io_req_ram", 32'(io_req), 32'd0);
                check("early_rvalid", 32'(i_rvalid | d_rvalid), 32'd0);
                for (int c = 1; c <= RAM_LAT; c++) begin
                    @(negedge clk);
                    check("ram_req_once", 32'(ram_req), 32'd0);
                    if (c == RAM_LAT) check_resp(is_d, 1'b0, ram_model(a), !we);
                    else check("early_rvalid", 32'(i_rvalid | d_rvalid), 32'd0);
                end
            end
            1: begin
                io_val = $urandom;
                for (int j = 0; j <= k; j++) begin
                    io_ready = (j == k);
                    io_rdata = (j == k) ? io_val : $urandom;
                    @(negedge clk);
                    check("io_req", 32'(io_req), 32'd1);
                    check("io_addr", 32'(io_addr), 32'(a));
                    check("io_we", 32'(io_we), 32'(we));
                    check("io_be", 32'(io_be), 32'(be));
                    if (we) check("io_wdata", io_wdata, wd);
                    check("ram_req_io", 32'(ram_req), 32'd0);
                    check("early_rvalid", 32'(i_rvalid | d_rvalid), 32'd0);
                    @(posedge clk); #1;
                end
                io_ready = 1'b0;
                @(negedge clk);
                check_resp(is_d, 1'b0, we ? 32'h0 : io_val, 1'b1);
                check("io_req_done", 32'(io_req), 32'd0);
            end
            default: begin
                @(negedge clk);
                check_resp(is_d, 1'b1, 32'h0, 1'b1);
                check("ram_req_err", 32'(ram_req), 32'd0);
                check("io_req_err", 32'(io_req), 32'd0);
            end
        endcase
        @(posedge clk); #1;
    endtask

    task automatic rand_fetch();
        i_addr = rand_addr();
    endtask

    task automatic rand_data();
        d_addr  = rand_addr();
        d_we    = 1'($urandom_range(0, 1));
        d_be    = 4'($urandom);
        d_wdata = $urandom;
    endtask

    initial begin
        bit w, w2;
        rst = 1'b1;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        io_ready = 0; io_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_i_gnt", 32'(i_gnt), 32'd0);
        check("rst_d_gnt", 32'(d_gnt), 32'd0);
        check("rst_rvalid", 32'(i_rvalid | d_rvalid), 32'd0);
        check("rst_err", 32'(i_err | d_err), 32'd0);
        check("rst_ram_req", 32'(ram_req), 32'd0);
        check("rst_io_req", 32'(io_req), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_rdata", i_rdata | d_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // contention, both RAM reads
        i_req = 1; i_addr = 30'h0000_0100;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 30'h0000_0200;
        pick(1'b1, 1'b1, w);
`ifdef ARB_ROUND_ROBIN_EN
        check("rr_first_fetch", 32'(w), 32'd0);
`else
        check("fixed_data_first", 32'(w), 32'd1);
`endif
        serve(w, 0);
        pick(w, !w, w2);
        serve(w2, 0);

        // fetch read of the DEAD_BEEF word
        i_req = 1; i_addr = 30'h0000_0010;
        pick(1'b1, 1'b0, w);
        serve(w, 0);

        // IO write, io_ready in the third io_req cycle
        d_req = 1; d_we = 1; d_be = 4'h1; d_addr = 30'h3C00_0004; d_wdata = 32'h0000_00A5;
        pick(1'b0, 1'b1, w);
        serve(w, 2);

        // unmapped read
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 30'h2000_0000;
        pick(1'b0, 1'b1, w);
        serve(w, 0);

        // reset during IO read
        d_req = 1; d_we = 0; d_addr = 30'h3C00_0008;
        @(negedge clk);
        check("rst_case_gnt", 32'(d_gnt), 32'd1);
        @(posedge clk); #1;
        d_req = 0;
        @(negedge clk);
        check("rst_case_io_req", 32'(io_req), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("abort_io_req", 32'(io_req), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_no_rvalid", 32'(d_rvalid | i_rvalid), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        rr_ptr = 1'b0;
        i_req = 1; i_addr = 30'h0000_0040;
        pick(1'b1, 1'b0, w);
        serve(w, 0);

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            int m;
            bit ir, dr;
            m  = $urandom_range(0, 3);
            ir = m[0];
            dr = m[1];
            rand_fetch();
            rand_data();
            i_req = ir;
            d_req = dr;
            if (!ir && !dr) begin
                @(negedge clk);
                check("idle_gnt", 32'(i_gnt | d_gnt), 32'd0);
                check("idle_strobes", 32'(ram_req | io_req), 32'd0);
                @(posedge clk); #1;
            end else begin
                pick(ir, dr, w);
                serve(w, $urandom_range(0, 3));
                if (ir && dr) begin
                    if (w) rand_fetch(); else rand_data();
                    pick(w, !w, w2);
                    serve(w2, $urandom_range(0, 3));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
